// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
//   Job sequencer for a weight-stationary systolic array. A job is:
//     1. ARRAY_SIZE weight rows, each forwarded to the array with a one-cycle
//        arr_load strobe;
//     2. num_rows activation rows, skewed so lane i enters the array i cycles
//        after lane 0;
//     3. de-skewing of the array's staggered result lanes back into whole rows,
//        tagged by a valid delay line so each accepted row yields one out_valid;
//     4. a one-cycle done pulse, then back to IDLE.
//
//   Ports
//     clk, reset            rising-edge clock, synchronous active-high reset
//     start, num_rows       job request (sampled in IDLE only), row count
//     busy, done            job status / one-cycle completion pulse
//     w_valid/w_ready/w_data  weight-row input handshake
//     a_valid/a_ready/a_data  activation-row input handshake
//     out_valid, out_data   de-skewed result rows (no backpressure)
//     arr_load, arr_weights, arr_activations, arr_output  array-side signals
//     perf_cycles, perf_stalls  performance counters
//
//   Configuration
//     SYSTOLIC_CTRL_PERF_EN  when defined, perf_cycles counts busy cycles and
//                            perf_stalls counts STREAM cycles with a_valid=0;
//                            both clear on reset and on an accepted start and
//                            saturate. When undefined both ports read 0.
//
//   Handshake semantics: a row transfers on every rising edge where valid and
//   ready are both high. The producer may raise valid at any time and may drop
//   it between rows (gaps are legal); ready depends only on controller state,
//   never on valid, so there is no combinational loop through the handshake.
// -----------------------------------------------------------------------------
module systolic_ctrl #(
    parameter int ARRAY_SIZE = 8,
    parameter int DATA_WIDTH = 4,
    parameter int ARRAY_LAT  = 8
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic [7:0]                                   num_rows,
    output logic                                         busy,
    output logic                                         done,
    input  logic                                         w_valid,
    output logic                                         w_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]             w_data,
    input  logic                                         a_valid,
    output logic                                         a_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]             a_data,
    output logic                                         out_valid,
    output logic [ARRAY_SIZE*DATA_WIDTH*DATA_WIDTH-1:0]  out_data,
    output logic                                         arr_load,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]             arr_weights,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]             arr_activations,
    input  logic [ARRAY_SIZE*DATA_WIDTH*DATA_WIDTH-1:0]  arr_output,
    output logic [31:0]                                  perf_cycles,
    output logic [31:0]                                  perf_stalls
);

    localparam int ROW_W     = ARRAY_SIZE * DATA_WIDTH;
    localparam int LANE_W    = DATA_WIDTH * DATA_WIDTH;
    localparam int OUT_W     = ARRAY_SIZE * LANE_W;
    localparam int TAG_DEPTH = ARRAY_LAT + ARRAY_SIZE;
    localparam int WCW       = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         rows_q, rows_d;
    logic [WCW-1:0]     w_cnt_q, w_cnt_d;
    logic [7:0]         a_cnt_q, a_cnt_d;
    logic               arr_load_q;
    logic [ROW_W-1:0]   arr_weights_q;
    logic [TAG_DEPTH-1:0] tag_q;
    logic [OUT_W-1:0]   aligned;

    logic w_fire;
    logic a_fire;
    logic start_fire;
    logic drain_last;

    assign w_fire     = w_valid && w_ready;
    assign a_fire     = a_valid && a_ready;
    assign start_fire = (state_q == IDLE) && start;

    // The oldest tag is on out_valid right now and nothing younger is in
    // flight: this is the final result row of the job.
    assign drain_last = tag_q[TAG_DEPTH-1] && (tag_q[TAG_DEPTH-2:0] == '0);

    // ------------------------------------------------------------------
    // FSM next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        w_cnt_d = w_cnt_q;
        a_cnt_d = a_cnt_q;
        w_ready = 1'b0;
        a_ready = 1'b0;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    rows_d  = num_rows;
                    w_cnt_d = '0;
                    state_d = LOAD_W;
                end
            end
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    w_cnt_d = w_cnt_q + WCW'(1);
                    if (w_cnt_q == WCW'(ARRAY_SIZE - 1)) begin
                        w_cnt_d = '0;
                        a_cnt_d = '0;
                        state_d = (rows_q == 8'd0) ? DONE : STREAM;
                    end
                end
            end
            STREAM: begin
                a_ready = 1'b1;
                if (a_valid) begin
                    a_cnt_d = a_cnt_q + 8'd1;
                    if (a_cnt_q == rows_q - 8'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rows_q        <= '0;
            w_cnt_q       <= '0;
            a_cnt_q       <= '0;
            arr_load_q    <= 1'b0;
            arr_weights_q <= '0;
            tag_q         <= '0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            w_cnt_q    <= w_cnt_d;
            a_cnt_q    <= a_cnt_d;
            arr_load_q <= w_fire;
            if (w_fire) begin
                arr_weights_q <= w_data;
            end
            tag_q <= {tag_q[TAG_DEPTH-2:0], a_fire};
        end
    end

    assign arr_load    = arr_load_q;
    assign arr_weights = arr_weights_q;
    assign out_valid   = tag_q[TAG_DEPTH-1];

    // ------------------------------------------------------------------
    // Input skew: lane i passes through i+1 registers. Idle cycles push
    // zeros so a gap never smears a previous row into the next one.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_skew
        logic [DATA_WIDTH-1:0] pipe_q [i+1];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s <= i; s++) begin
                    pipe_q[s] <= '0;
                end
            end else begin
                pipe_q[0] <= a_fire ? a_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int s = 1; s <= i; s++) begin
                    pipe_q[s] <= pipe_q[s-1];
                end
            end
        end

        assign arr_activations[i*DATA_WIDTH +: DATA_WIDTH] = pipe_q[i];
    end

    // ------------------------------------------------------------------
    // Output de-skew: lane j leaves the array j cycles after lane 0, so it
    // is delayed ARRAY_SIZE-1-j cycles; the last lane passes straight through.
    // ------------------------------------------------------------------
    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_deskew
        localparam int DLY = ARRAY_SIZE - 1 - j;

        if (DLY == 0) begin : g_pass
            assign aligned[j*LANE_W +: LANE_W] = arr_output[j*LANE_W +: LANE_W];
        end else begin : g_dly
            logic [LANE_W-1:0] dly_q [DLY];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < DLY; s++) begin
                        dly_q[s] <= '0;
                    end
                end else begin
                    dly_q[0] <= arr_output[j*LANE_W +: LANE_W];
                    for (int s = 1; s < DLY; s++) begin
                        dly_q[s] <= dly_q[s-1];
                    end
                end
            end

            assign aligned[j*LANE_W +: LANE_W] = dly_q[DLY-1];
        end
    end

    // The pass-through lane is combinational from the array, so the row is
    // gated by its valid tag to keep out_data at zero between results and
    // straight after reset.
    assign out_data = out_valid ? aligned : '0;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_stalls_q;

    always_ff @(posedge clk) begin
        if (reset || start_fire) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (busy && !(&perf_cycles_q)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if ((state_q == STREAM) && !a_valid && !(&perf_stalls_q)) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`else
    logic unused_start_fire;
    assign unused_start_fire = start_fire;
    assign perf_cycles       = '0;
    assign perf_stalls       = '0;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_ctrl
//   Drives jobs into systolic_ctrl while a behavioural array model sits on the
//   array-side ports. The model forms result lane j from the skewed activation
//   stream exactly as a real array would (lane i of a row entering lane 0 at
//   cycle e is taken from cycle e+i; lane j is produced at e+ARRAY_LAT+j), so
//   result rows only match when skew and de-skew are both right.
//   Expected rows are computed from the driven activation row and the driven
//   weight rows and queued with their due cycle; the monitor pops them when
//   out_valid fires. arr_load strobes are scoreboarded the same way.
// -----------------------------------------------------------------------------
module tb_systolic_ctrl;

    localparam int N   = 8;
    localparam int DW  = 4;
    localparam int LAT = 8;
    localparam int RW  = N * DW;
    localparam int LW  = DW * DW;
    localparam int OW  = N * LW;
    localparam int HD  = 64;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    num_rows = '0;
    logic          busy, done;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [RW-1:0] w_data = '0;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [RW-1:0] a_data = '0;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          arr_load;
    logic [RW-1:0] arr_weights;
    logic [RW-1:0] arr_activations;
    logic [OW-1:0] arr_output = '0;
    logic [31:0]   perf_cycles, perf_stalls;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_ctrl #(
        .ARRAY_SIZE(N),
        .DATA_WIDTH(DW),
        .ARRAY_LAT (LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_rows       (num_rows),
        .busy           (busy),
        .done           (done),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .w_data         (w_data),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .a_data         (a_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .arr_load       (arr_load),
        .arr_weights    (arr_weights),
        .arr_activations(arr_activations),
        .arr_output     (arr_output),
        .perf_cycles    (perf_cycles),
        .perf_stalls    (perf_stalls)
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    logic [OW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [RW-1:0] ld_exp_q[$];
    int            ld_cyc_q[$];

    logic [RW-1:0] w_rows [N];

    int done_cnt = 0;
    int done_cyc = 0;
    int last_out_cyc = 0;
    int last_load_cyc = 0;
    int job_outs = 0;
    int job_loads = 0;
    int job_done0 = 0;
    int busy_cnt = 0;
    bit done_prev = 1'b0;

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural array ----------------
    logic [RW-1:0] hist [HD];
    logic [RW-1:0] wmat [N];
    int            ld_idx = 0;

    initial begin
        for (int k = 0; k < HD; k++) hist[k] = '0;
        for (int k = 0; k < N; k++) wmat[k] = '0;
    end

    always @(posedge clk) begin
        logic [LW-1:0] acc;
        logic [RW-1:0] row;
        logic [OW-1:0] res;
        int            idx;
        #1;
        hist[cyc % HD] = arr_activations;
        if (arr_load) begin
            wmat[ld_idx] = arr_weights;
            ld_idx = (ld_idx + 1) % N;
        end
        res = '0;
        for (int j = 0; j < N; j++) begin
            acc = '0;
            for (int i = 0; i < N; i++) begin
                idx = cyc - LAT - j + i;
                if (idx >= 0) begin
                    row = hist[idx % HD];
                    acc = acc + LW'(row[i*DW +: DW]) * LW'(wmat[i][j*DW +: DW]);
                end
            end
            res[j*LW +: LW] = acc;
        end
        arr_output = res;
    end

    // Expected result row: a x W, lane j = sum_i a[i] * W[i][j].
    function automatic logic [OW-1:0] golden(input logic [RW-1:0] a);
        logic [OW-1:0] r;
        logic [LW-1:0] acc;
        r = '0;
        for (int j = 0; j < N; j++) begin
            acc = '0;
            for (int i = 0; i < N; i++) begin
                acc = acc + LW'(a[i*DW +: DW]) * LW'(w_rows[i][j*DW +: DW]);
            end
            r[j*LW +: LW] = acc;
        end
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset) begin
            done_prev = 1'b0;
        end else begin
            if (done_prev) begin
                check("busy_after_done", OW'(busy), OW'(0));
                check("done_one_cycle", OW'(done), OW'(0));
            end
            done_prev = done;
            if (busy) busy_cnt++;
            if (arr_load) begin
                job_loads++;
                last_load_cyc = cyc;
                check("load_expected", OW'(ld_cyc_q.size() != 0), OW'(1));
                if (ld_cyc_q.size() != 0) begin
                    check("arr_load_cycle", OW'(cyc), OW'(ld_cyc_q.pop_front()));
                    check("arr_weights", OW'(arr_weights), OW'(ld_exp_q.pop_front()));
                end
            end
            if (out_valid) begin
                job_outs++;
                last_out_cyc = cyc;
                check("out_expected", OW'(exp_cyc_q.size() != 0), OW'(1));
                if (exp_cyc_q.size() != 0) begin
                    check("out_cycle", OW'(cyc), OW'(exp_cyc_q.pop_front()));
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers run at 1 time unit after a rising edge.
    task automatic set_identity();
        for (int i = 0; i < N; i++) begin
            w_rows[i] = '0;
            w_rows[i][i*DW +: DW] = DW'(1);
        end
    endtask

    task automatic set_random();
        for (int i = 0; i < N; i++) w_rows[i] = RW'($urandom);
    endtask

    task automatic start_job(input int n);
        job_outs  = 0;
        job_loads = 0;
        job_done0 = done_cnt;
        busy_cnt  = 0;
        start     = 1'b1;
        num_rows  = 8'(n);
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic load_weights(input int stall_at);
        int acc = 0;
        int guard = 0;
        int gap = 0;
        while (acc < N && guard < 200) begin
            if (w_ready && !(acc == stall_at && gap < 5)) begin
                w_valid = 1'b1;
                w_data  = w_rows[acc];
                ld_exp_q.push_back(w_rows[acc]);
                ld_cyc_q.push_back(cyc + 1);
                acc++;
            end else begin
                w_valid = 1'b0;
                w_data  = RW'($urandom);
                if (w_ready) gap++;
            end
            @(posedge clk); #1;
            guard++;
        end
        w_valid = 1'b0;
        check("weights_accepted", OW'(acc), OW'(N));
    endtask

    // gap_mode: 0 back-to-back, 1 every other cycle, 2 random gaps
    task automatic send_acts(input int n, input int gap_mode, input bit hold_start);
        int sent = 0;
        int guard = 0;
        bit phase = 1'b0;
        bit go;
        while (sent < n && guard < 400) begin
            if (hold_start) begin
                start    = 1'b1;
                num_rows = 8'd7;
            end
            go = 1'b0;
            if (a_ready) begin
                case (gap_mode)
                    1:       go = !phase;
                    2:       go = ($urandom_range(0, 2) != 0);
                    default: go = 1'b1;
                endcase
                phase = ~phase;
            end
            if (go) begin
                a_valid = 1'b1;
                a_data  = RW'($urandom);
                exp_q.push_back(golden(a_data));
                exp_cyc_q.push_back(cyc + LAT + N);
                sent++;
            end else begin
                a_valid = 1'b0;
                a_data  = RW'($urandom);
            end
            @(posedge clk); #1;
            guard++;
        end
        a_valid = 1'b0;
        start   = 1'b0;
        check("rows_accepted", OW'(sent), OW'(n));
    endtask

    task automatic finish_job(input int rows);
        int g = 0;
        while (done_cnt == job_done0 && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("done_count", OW'(done_cnt - job_done0), OW'(1));
        check("out_count", OW'(job_outs), OW'(rows));
        check("load_count", OW'(job_loads), OW'(N));
        check("exp_q_empty", OW'(exp_q.size()), OW'(0));
        if (rows > 0) check("done_after_last_out", OW'(done_cyc), OW'(last_out_cyc + 1));
        else          check("done_after_last_load", OW'(done_cyc), OW'(last_load_cyc));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        int exp_stalls;
        int exp_pcyc;

        // reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", OW'(busy), OW'(0));
        check("rst_done", OW'(done), OW'(0));
        check("rst_w_ready", OW'(w_ready), OW'(0));
        check("rst_a_ready", OW'(a_ready), OW'(0));
        check("rst_out_valid", OW'(out_valid), OW'(0));
        check("rst_arr_load", OW'(arr_load), OW'(0));
        check("rst_arr_weights", OW'(arr_weights), OW'(0));
        check("rst_arr_act", OW'(arr_activations), OW'(0));
        check("rst_out_data", out_data, OW'(0));
        check("rst_perf_cycles", OW'(perf_cycles), OW'(0));
        check("rst_perf_stalls", OW'(perf_stalls), OW'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // identity weights, three back-to-back rows
        set_identity();
        start_job(3);
        check("load_w_ready", OW'(w_ready), OW'(1));
        load_weights(-1);
        send_acts(3, 0, 1'b0);
        finish_job(3);

        // empty job: weights only, straight to done
        set_random();
        start_job(0);
        load_weights(-1);
        finish_job(0);

        // four rows with a gap every other cycle
        set_random();
        start_job(4);
        load_weights(-1);
        send_acts(4, 1, 1'b0);
        finish_job(4);
`ifdef SYSTOLIC_CTRL_PERF_EN
        exp_stalls = 3;
        exp_pcyc   = busy_cnt;
`else
        exp_stalls = 0;
        exp_pcyc   = 0;
`endif
        check("perf_stalls", OW'(perf_stalls), OW'(exp_stalls));
        check("perf_cycles", OW'(perf_cycles), OW'(exp_pcyc));

        // weight stream stalls five cycles mid-load, random activation gaps
        set_random();
        start_job(5);
        load_weights(4);
        send_acts(5, 2, 1'b0);
        finish_job(5);

        // reset while the second activation row is offered
        set_random();
        start_job(5);
        load_weights(-1);
        d0 = done_cnt;
        check("stream_a_ready", OW'(a_ready), OW'(1));
        a_valid = 1'b1;
        a_data  = RW'($urandom);
        exp_q.push_back(golden(a_data));
        exp_cyc_q.push_back(cyc + LAT + N);
        @(posedge clk); #1;
        a_data = RW'($urandom);
        reset  = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        a_valid = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        check("abort_busy", OW'(busy), OW'(0));
        check("abort_out_valid", OW'(out_valid), OW'(0));
        repeat (30) begin
            @(posedge clk); #1;
        end
        check("abort_no_done", OW'(done_cnt - d0), OW'(0));
        check("abort_idle", OW'(busy), OW'(0));

        // fresh job after the abort
        set_random();
        start_job(2);
        load_weights(-1);
        send_acts(2, 0, 1'b0);
        finish_job(2);

        // start held high (with a different row count) while streaming
        set_random();
        start_job(3);
        load_weights(-1);
        send_acts(3, 0, 1'b1);
        finish_job(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 8, the array dimension (lanes).
REQ-002 SHALL have parameter DATA_WIDTH, default 4, the operand width per lane.
REQ-003 SHALL have parameter ARRAY_LAT, default 8, the array cycles from skewed lane-0 entry to lane-0 result.
REQ-004 SHALL have ports, in this order:
- clk  input  1  sole clock; rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  begin job; sampled only in IDLE.
- num_rows  input  8  activation rows in the job; latched on start.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at job completion.
- w_valid / w_ready  input / output  1 / 1  weight-row handshake.
- w_data  input  ARRAY_SIZE*DATA_WIDTH  one weight row.
- a_valid / a_ready  input / output  1 / 1  activation-row handshake.
- a_data  input  ARRAY_SIZE*DATA_WIDTH  one activation row; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  de-skewed result row valid.
- out_data  output  ARRAY_SIZE*DATA_WIDTH*DATA_WIDTH  result row; lane width DATA_WIDTH*DATA_WIDTH.
- arr_load  output  1  to the array load input.
- arr_weights  output  ARRAY_SIZE*DATA_WIDTH  to the array weights input.
- arr_activations  output  ARRAY_SIZE*DATA_WIDTH  to the array activations input (skewed).
- arr_output  input  ARRAY_SIZE*DATA_WIDTH*DATA_WIDTH  from the array output_row.
- perf_cycles / perf_stalls  output  32 / 32  performance counters (REQ-021).

Function
REQ-005 SHALL implement the states IDLE, LOAD_W, STREAM, DRAIN and DONE.
REQ-006 In IDLE, start=1 SHALL latch num_rows and go to LOAD_W; start in any other state SHALL be ignored.
REQ-007 LOAD_W SHALL hold w_ready=1 and accept one row per w_valid&w_ready cycle.
REQ-008 Each accepted weight row SHALL drive arr_weights=w_data with arr_load=1 on the next cycle, for that cycle only; arr_load SHALL be 0 otherwise.
REQ-009 After ARRAY_SIZE accepted weight rows, the FSM SHALL go to STREAM, or directly to DONE if num_rows==0.
REQ-010 STREAM SHALL hold a_ready=1 until num_rows rows are accepted, then go to DRAIN with a_ready=0.
REQ-011 Input skew: lane i of an accepted row SHALL reach arr_activations exactly 1+i cycles after acceptance.
REQ-012 Cycles without an accepted row (a_valid=0) SHALL inject zero lanes into the skew line; gaps are legal and SHALL NOT stall the job.
REQ-013 Output de-skew: lane j of arr_output SHALL be delayed ARRAY_SIZE-1-j cycles before out_data.
REQ-014 A row accepted at cycle t SHALL appear on out_data with out_valid=1 at cycle t+ARRAY_LAT+ARRAY_SIZE.
REQ-015 A valid-tag delay line SHALL generate out_valid: exactly one pulse per accepted row, in acceptance order, with no output backpressure.
REQ-016 DRAIN SHALL last until the last out_valid has been emitted, then go to DONE.
REQ-017 DONE SHALL assert done=1 for one cycle and return to IDLE; busy SHALL be 0 in that IDLE cycle.
REQ-018 w_ready SHALL be 0 outside LOAD_W, and a_ready SHALL be 0 outside STREAM.

Reset
REQ-019 On reset=1 at a clock edge, the block SHALL:
- go to IDLE and clear all counters, skew and de-skew registers and the valid-tag line;
- drive busy, done, w_ready, a_ready, out_valid and arr_load to 0;
- drive arr_weights, arr_activations and out_data to all-zero.
REQ-020 Reset asserted mid-job SHALL abort the job: no done pulse, and no out_valid on the cycle after reset.

Configuration
REQ-021 Macro SYSTOLIC_CTRL_PERF_EN, when defined:
- perf_cycles SHALL count cycles with busy=1;
- perf_stalls SHALL count STREAM cycles with a_valid=0;
- both SHALL clear on reset and on an accepted start, and saturate at all-ones.
When the macro is undefined, both ports SHALL be present and tied to 0.

Verification (ARRAY_SIZE=8, DATA_WIDTH=4, ARRAY_LAT=8)
REQ-022 Identity weights, num_rows=3, back-to-back rows -> three out_valid pulses at t+16, t+17 and t+18; out_data matches the golden array model; done one cycle after the last pulse.
REQ-023 num_rows=0 -> 8 arr_load pulses, then done with zero out_valid pulses.
REQ-024 num_rows=4 with a_valid low every other cycle -> outputs spaced 2 cycles apart; perf_stalls=3 with the macro defined, 0 without.
REQ-025 w_valid stalled 5 cycles mid-load -> exactly 8 arr_load pulses, none during the stall.
REQ-026 Reset at the second accepted activation row -> busy=0 and out_valid=0 on the next cycle, and no done; a fresh start then completes normally.
REQ-027 start held high during STREAM -> ignored; num_rows unchanged; single done.
